// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared widths and FSM state type for the ALU share arbiter
package alu_share_arbiter_pkg;

   localparam int W  = 4;
   localparam int N  = 4;
   localparam int GW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester/ALU bundle seen by the ALU share arbiter
interface alu_share_arbiter_if;
   import alu_share_arbiter_pkg::*;

   logic [N-1:0]   req;
   logic [N*W-1:0] op_a;
   logic [N*W-1:0] op_b;
   logic [N-1:0]   ack;
   logic [W-1:0]   rsp_c;
   logic           rsp_zero;
   logic           rsp_ovf;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [W-1:0]   alu_c;
   logic           busy;

   // Requesters and the external ALU together form the master side.
   modport master (
      output req, op_a, op_b, alu_c,
      input  ack, rsp_c, rsp_zero, rsp_ovf, alu_a, alu_b, busy
   );

   modport slave (
      input  req, op_a, op_b, alu_c,
      output ack, rsp_c, rsp_zero, rsp_ovf, alu_a, alu_b, busy
   );

endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// rtl/alu_share_arbiter_rr_picker.sv - combinational round-robin selector starting after last_grant
module rr_picker
   import alu_share_arbiter_pkg::*;
(
   input  logic [N-1:0]  eligible_i,
   input  logic [GW-1:0] last_grant_i,
   output logic          valid_o,
   output logic [GW-1:0] grant_o
);

   logic [GW-1:0] idx;

   // Scan from the farthest candidate back to the nearest so the first eligible one wins.
   always_comb begin
      valid_o = 1'b0;
      grant_o = '0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = GW'((int'(last_grant_i) + 1 + k) % N);
         if (eligible_i[idx]) begin
            valid_o = 1'b1;
            grant_o = idx;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered ALU among N requesters
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   alu_share_arbiter_if.slave  bus
);

   state_e        state_q, state_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;
   logic [W-1:0]  rsp_c_q, rsp_c_d;
   logic          rsp_zero_q, rsp_zero_d;
   logic          rsp_ovf_q, rsp_ovf_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;

   logic [N-1:0]  eligible;
   logic          pick_valid;
   logic [GW-1:0] pick_grant;

   // A requester still holding req during its own ack must not be re-granted.
   assign eligible = bus.req & ~ack_q;

   rr_picker u_picker (
      .eligible_i   (eligible),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .grant_o      (pick_grant)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_c_q      <= '0;
         rsp_zero_q   <= 1'b1;
         rsp_ovf_q    <= 1'b0;
         carry_q      <= 1'b0;
         ack_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= GW'(N - 1);
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_c_q      <= rsp_c_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_ovf_q    <= rsp_ovf_d;
         carry_q      <= carry_d;
         ack_q        <= ack_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_c_d      = rsp_c_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_ovf_d    = rsp_ovf_q;
      carry_d      = carry_q;
      ack_d        = '0;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               alu_a_d = bus.op_a[int'(pick_grant) * W +: W];
               alu_b_d = bus.op_b[int'(pick_grant) * W +: W];
               grant_d = pick_grant;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // a + b carries out exactly when a exceeds the headroom left by b.
            carry_d = (alu_a_q > ~alu_b_q);
            state_d = CAPTURE;
         end
         CAPTURE: begin
            rsp_c_d        = bus.alu_c;
            rsp_zero_d     = (bus.alu_c == '0);
            rsp_ovf_d      = carry_q;
            ack_d[grant_q] = 1'b1;
            last_grant_d   = grant_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ack      = ack_q;
   assign bus.rsp_c    = rsp_c_q;
   assign bus.rsp_zero = rsp_zero_q;
   assign bus.rsp_ovf  = rsp_ovf_q;
   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic CLK;
   logic RST;
   int   n_cmp;
   int   n_bad;

   alu_share_arbiter_if bus ();

   alu_share_arbiter dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External registered ALU
   always @(posedge CLK) bus.alu_c <= bus.alu_a + bus.alu_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(output int cyc, output logic [3:0] a);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (bus.ack == 4'b0 && cyc < 12);
      a = bus.ack;
   endtask

   task automatic check_rsp(input string tag, input logic [3:0] c, input logic z, input logic o);
      check({tag, "_rsp_c"}, 32'(bus.rsp_c), 32'(c));
      check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(z));
      check({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(o));
   endtask

   logic [3:0] exp_c [4] = '{4'd2, 4'd7, 4'd0, 4'd1};
   logic       exp_z [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic       exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int         cyc;
      logic [3:0] a;
      int         extra;
      n_cmp = 0;
      n_bad = 0;
      RST      = 1'b0;
      bus.req  = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      tick();
      tick();

      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check_rsp("rst", 4'd0, 1'b1, 1'b0);

      // Single request 3+4
      RST      = 1'b1;
      bus.op_a = 16'h0003;
      bus.op_b = 16'h0004;
      bus.req  = 4'b0001;
      wait_ack(cyc, a);
      check("single_lat", 32'(cyc), 32'd3);
      check("single_ack", 32'(a), 32'b0001);
      check_rsp("single", 4'd7, 1'b0, 1'b0);
      bus.req = 4'b0000;
      tick();
      check("single_pulse", 32'(bus.ack), 32'd0);
      check("single_idle", 32'(bus.busy), 32'd0);
      check_rsp("single_hold", 4'd7, 1'b0, 1'b0);

      // Wrap-around on requester 2: 15+1
      bus.op_a = 16'h0F00;
      bus.op_b = 16'h0100;
      bus.req  = 4'b0100;
      wait_ack(cyc, a);
      check("wrap_lat", 32'(cyc), 32'd3);
      check("wrap_ack", 32'(a), 32'b0100);
      check_rsp("wrap", 4'd0, 1'b1, 1'b1);
      bus.req = 4'b0000;
      tick();

      // Contention after a fresh reset
      RST = 1'b0;
      tick();
      RST      = 1'b1;
      bus.op_a = 16'hC921;
      bus.op_b = 16'h5751;
      bus.req  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(cyc, a);
         check($sformatf("cont%0d_lat", k), 32'(cyc), 32'd3);
         check($sformatf("cont%0d_ack", k), 32'(a), 32'(4'b0001 << k));
         check_rsp($sformatf("cont%0d", k), exp_c[k], exp_z[k], exp_o[k]);
         bus.req[k] = 1'b0;
      end
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.ack != 4'b0) extra++;
      end
      check("cont_no_repeat", 32'(extra), 32'd0);

      // Fairness: requesters 0 and 1 keep requesting
      bus.op_a = 16'h0035;
      bus.op_b = 16'h0035;
      bus.req  = 4'b0011;
      for (int k = 0; k < 20; k++) begin
         wait_ack(cyc, a);
         check($sformatf("fair%0d_lat", k), 32'(cyc), 32'd3);
         check($sformatf("fair%0d_ack", k), 32'(a), (k % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("fair%0d_c", k), 32'(bus.rsp_c), (k % 2 == 0) ? 32'd10 : 32'd6);
      end
      bus.req = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      check("fair_drain", 32'(bus.busy), 32'd0);

      // Reset during ISSUE
      bus.op_a = 16'h0060;
      bus.op_b = 16'h0090;
      bus.req  = 4'b0010;
      tick();
      check("mid_busy", 32'(bus.busy), 32'd1);
      check("mid_alu_a", 32'(bus.alu_a), 32'd6);
      RST = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("mid_rst_ack", 32'(bus.ack), 32'd0);
      check_rsp("mid_rst", 4'd0, 1'b1, 1'b0);
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus.ack != 4'b0) extra++;
      end
      check("mid_no_ack", 32'(extra), 32'd0);
      RST = 1'b1;
      wait_ack(cyc, a);
      check("mid_lat", 32'(cyc), 32'd3);
      check("mid_ack", 32'(a), 32'b0010);
      check_rsp("mid", 4'd15, 1'b0, 1'b0);
      bus.req = 4'b0000;
      tick();

      // Operand change and req drop after grant
      bus.op_a = 16'h0002;
      bus.op_b = 16'h0003;
      bus.req  = 4'b0001;
      tick();
      bus.op_a = 16'h0009;
      bus.req  = 4'b0000;
      check("opchg_alu_a", 32'(bus.alu_a), 32'd2);
      wait_ack(cyc, a);
      check("opchg_lat", 32'(cyc), 32'd2);
      check("opchg_ack", 32'(a), 32'b0001);
      check_rsp("opchg", 4'd5, 1'b0, 1'b0);
      tick();
      check("opchg_pulse", 32'(bus.ack), 32'd0);
      check("opchg_hold", 32'(bus.rsp_c), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: W, 4, operand/result width; the only supported value is 4, matching the shared ALU.
REQ-002 Parameter: N, 4, number of requesters; the only supported value is 4.
REQ-003 CLK  input  1  clock; all state updates on posedge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  per-requester request, level, held until that requester's ack.
REQ-006 op_a  input  N*W  packed A operands; requester i occupies bits [i*W+W-1 : i*W].
REQ-007 op_b  input  N*W  packed B operands; same packing as op_a.
REQ-008 ack  output  N  one-hot, single-cycle completion pulse to the granted requester.
REQ-009 rsp_c  output  W  result of the last completed operation.
REQ-010 rsp_zero  output  1  rsp_c == 0 for the last completed operation.
REQ-011 rsp_ovf  output  1  carry-out (bit W of A+B) for the last completed operation.
REQ-012 alu_a  output  W  operand A driven to the shared registered ALU.
REQ-013 alu_b  output  W  operand B driven to the shared registered ALU.
REQ-014 alu_c  input  W  registered ALU result; valid one cycle after alu_a/alu_b are presented.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE; encoding is 2 bits.
REQ-017 IDLE transitions:
- eligible = req & ~ack;
- if eligible != 0: select a grant, register op_a/op_b of the granted requester into alu_a/alu_b, go to ISSUE;
- otherwise stay in IDLE.
REQ-018 Grant selection is round-robin: search starts at (last_grant+1) mod N, and the first eligible index wins.
REQ-019 ISSUE lasts exactly one cycle and always transitions to CAPTURE; alu_a/alu_b hold their value in ISSUE and CAPTURE.
REQ-020 ISSUE computes carry = bit W of ({1'b0,alu_a}+{1'b0,alu_b}) and registers it internally.
REQ-021 CAPTURE lasts one cycle; on exiting it:
- rsp_c <= alu_c;
- rsp_zero <= (alu_c == 0);
- rsp_ovf <= registered carry;
- ack[grant] <= 1;
- last_grant <= grant;
- next state IDLE.
REQ-022 ack is high for exactly one cycle; latency from the IDLE cycle that samples req to the ack-high cycle is 3 cycles.
REQ-023 Back-to-back operation: in the ack-high cycle the FSM is in IDLE and may grant another requester, giving a sustained throughput of one operation per 3 cycles.
REQ-024 The requester being acked is masked for that cycle (REQ-017), so a req still held during its ack is not re-granted.
REQ-025 A req deasserted while granted does not abort the operation; it completes and acks normally.
REQ-026 Changes to op_a/op_b after the grant cycle do not affect the result.
REQ-027 Arithmetic is unsigned modulo 2^W; wrap-around, e.g. 15+1 gives rsp_c=0, rsp_zero=1, rsp_ovf=1.
REQ-028 rsp_c, rsp_zero and rsp_ovf hold their value between completions.

Reset
REQ-029 RST low asynchronously forces:
- state = IDLE;
- ack = 0;
- alu_a = alu_b = 0;
- rsp_c = 0, rsp_zero = 1, rsp_ovf = 0;
- last_grant = N-1, so requester 0 has first priority;
- busy = 0.
REQ-030 RST asserted mid-operation abandons the operation with no ack; after release, pending requests are re-arbitrated from requester 0.

Structure
REQ-031 The shared package holds: W, N, the FSM state constants IDLE/ISSUE/CAPTURE, and the 2-bit state type.
REQ-032 Sub-module rr_picker: combinational round-robin selector; inputs eligible[N] and last_grant; outputs a valid flag and a grant index. The FSM and datapath stay in alu_share_arbiter.
REQ-033 The ALU is external; alu_a, alu_b and alu_c are its only connection.

Verification
REQ-034 Single request: req=0001, op_a[3:0]=3, op_b[3:0]=4 -> ack=0001 exactly 3 cycles later; rsp_c=7, rsp_zero=0, rsp_ovf=0.
REQ-035 Wrap-around: requester 2 with A=15, B=1 -> ack=0100; rsp_c=0, rsp_zero=1, rsp_ovf=1.
REQ-036 Contention: req=1111 held after reset, each requester dropping req after its ack -> acks in order 0001, 0010, 0100, 1000, spaced 3 cycles apart, with no requester acked twice.
REQ-037 Fairness: requesters 0 and 1 re-raise req immediately after each ack -> grants alternate 0,1,0,1; no starvation over 20 operations.
REQ-038 Reset mid-operation: assert RST in the ISSUE cycle -> no ack; outputs at reset values; after release, the pending req=0010 is served with correct data.
REQ-039 Operand change: alter op_a one cycle after the grant -> rsp_c reflects the originally sampled operands.
